// File: rtl/test_cmd_resp_pkg.sv
// rtl/test_cmd_resp_pkg.sv - shared state type, word-count width and log mask helper
package test_cmd_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ARMED = 2'd2,
    VAL   = 2'd3
  } state_e;

  localparam int WORD_CNT_W = 16;

  function automatic logic [31:0] log_mask(input int unsigned shift);
    return (32'd1 << shift) - 32'd1;
  endfunction

endpackage

// File: rtl/resp_wrap_counter.sv
// rtl/resp_wrap_counter.sv - wrap-around validate counter with load-to-1, wrap and log-hit flags
module resp_wrap_counter
  import test_cmd_resp_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int LOG_SHIFT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             log_hit_o
);

  localparam logic [CNT_W-1:0] LOG_MASK = CNT_W'(log_mask(LOG_SHIFT));
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = ONE;
    end else if (inc_i) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // wrap_o flags the all-ones value, i.e. the next increment returns to 0
  assign cnt_o     = cnt_q;
  assign wrap_o    = &cnt_q;
  assign log_hit_o = ((cnt_q & LOG_MASK) == ONE);

endmodule

// File: rtl/test_cmd_responder.sv
// rtl/test_cmd_responder.sv - SelectTest/Validate strobe responder: stream scan, then validate count loop
// Optional word_cnt_o scan beat counter under TEST_CMD_RESP_WORD_COUNT_EN.
module test_cmd_responder
  import test_cmd_resp_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int LOG_SHIFT = 10,
  parameter int CTR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              select_test_i,
  input  logic              validate_i,
  input  logic [CTR_W-1:0]  ctr_i,
  output logic              rd_req_o,
  input  logic              rd_valid_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              rd_eof_i,
  output logic              log_valid_o,
  output logic [CNT_W-1:0]  log_data_o,
  output logic              busy_o,
  output logic              sel_done_o,
  output logic              val_done_o,
  output logic [CTR_W-1:0]  done_ctr_o,
  output logic              err_o
`ifdef TEST_CMD_RESP_WORD_COUNT_EN
  ,
  output logic [WORD_CNT_W-1:0] word_cnt_o
`endif
);

  state_e             state_q, state_d;
  logic [CTR_W-1:0]   done_ctr_q, done_ctr_d;
  logic               sel_done_q, sel_done_d;
  logic               val_done_q, val_done_d;
  logic               err_q, err_d;
  logic               log_valid_q, log_valid_d;
  logic [CNT_W-1:0]   log_data_q, log_data_d;
  logic               cnt_load, cnt_inc, cnt_wrap, cnt_log_hit;
  logic [CNT_W-1:0]   cnt;
  logic               unused_rd_data;

  assign unused_rd_data = ^rd_data_i;

  resp_wrap_counter #(
    .CNT_W     (CNT_W),
    .LOG_SHIFT (LOG_SHIFT)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .inc_i     (cnt_inc),
    .cnt_o     (cnt),
    .wrap_o    (cnt_wrap),
    .log_hit_o (cnt_log_hit)
  );

  always_comb begin
    state_d    = state_q;
    done_ctr_d = done_ctr_q;
    sel_done_d = 1'b0;
    val_done_d = 1'b0;
    err_d      = 1'b0;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (select_test_i) begin
          state_d    = SCAN;
          done_ctr_d = ctr_i;
          err_d      = validate_i;
        end else if (validate_i) begin
          err_d = 1'b1;
        end
      end
      SCAN: begin
        err_d = select_test_i | validate_i;
        if (rd_valid_i && rd_eof_i) begin
          state_d    = ARMED;
          sel_done_d = 1'b1;
        end
      end
      ARMED: begin
        if (validate_i) begin
          state_d    = VAL;
          done_ctr_d = ctr_i;
          cnt_load   = 1'b1;
          err_d      = select_test_i;
        end else if (select_test_i) begin
          state_d    = SCAN;
          done_ctr_d = ctr_i;
        end
      end
      VAL: begin
        err_d = select_test_i | validate_i;
        // The cycle holding the wrapped 0 is the last VAL cycle; leave without counting on
        if (val_done_q) begin
          state_d = IDLE;
        end else begin
          cnt_inc    = 1'b1;
          val_done_d = cnt_wrap;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    log_valid_d = (state_q == VAL) && cnt_log_hit;
    log_data_d  = log_valid_d ? cnt : log_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      done_ctr_q  <= '0;
      sel_done_q  <= 1'b0;
      val_done_q  <= 1'b0;
      err_q       <= 1'b0;
      log_valid_q <= 1'b0;
      log_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      done_ctr_q  <= done_ctr_d;
      sel_done_q  <= sel_done_d;
      val_done_q  <= val_done_d;
      err_q       <= err_d;
      log_valid_q <= log_valid_d;
      log_data_q  <= log_data_d;
    end
  end

`ifdef TEST_CMD_RESP_WORD_COUNT_EN
  logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (state_q != SCAN && state_d == SCAN) begin
      word_cnt_d = '0;
    end else if (state_q == SCAN && rd_valid_i && !(&word_cnt_q)) begin
      word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt_o = word_cnt_q;
`endif

  assign rd_req_o    = (state_q == SCAN);
  assign busy_o      = (state_q == SCAN) || (state_q == VAL);
  assign sel_done_o  = sel_done_q;
  assign val_done_o  = val_done_q;
  assign done_ctr_o  = done_ctr_q;
  assign err_o       = err_q;
  assign log_valid_o = log_valid_q;
  assign log_data_o  = log_data_q;

endmodule

// File: tb/tb_test_cmd_responder.sv
// tb/tb_test_cmd_responder.sv - randomized directed bench for test_cmd_responder (honours TEST_CMD_RESP_WORD_COUNT_EN)
module tb_test_cmd_responder;

  localparam int DATA_W    = 32;
  localparam int CNT_W     = 12;
  localparam int LOG_SHIFT = 10;
  localparam int CTR_W     = 32;
  localparam int PERIOD    = 1 << CNT_W;
  localparam int LOG_STEP  = 1 << LOG_SHIFT;
  localparam int LOGS      = 1 << (CNT_W - LOG_SHIFT);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              select_test_i = 1'b0;
  logic              validate_i = 1'b0;
  logic [CTR_W-1:0]  ctr_i = '0;
  logic              rd_req_o;
  logic              rd_valid_i = 1'b0;
  logic [DATA_W-1:0] rd_data_i = '0;
  logic              rd_eof_i = 1'b0;
  logic              log_valid_o;
  logic [CNT_W-1:0]  log_data_o;
  logic              busy_o;
  logic              sel_done_o;
  logic              val_done_o;
  logic [CTR_W-1:0]  done_ctr_o;
  logic              err_o;
`ifdef TEST_CMD_RESP_WORD_COUNT_EN
  logic [15:0]       word_cnt_o;
`endif

  test_cmd_responder #(
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .LOG_SHIFT (LOG_SHIFT),
    .CTR_W     (CTR_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .select_test_i (select_test_i),
    .validate_i    (validate_i),
    .ctr_i         (ctr_i),
    .rd_req_o      (rd_req_o),
    .rd_valid_i    (rd_valid_i),
    .rd_data_i     (rd_data_i),
    .rd_eof_i      (rd_eof_i),
    .log_valid_o   (log_valid_o),
    .log_data_o    (log_data_o),
    .busy_o        (busy_o),
    .sel_done_o    (sel_done_o),
    .val_done_o    (val_done_o),
    .done_ctr_o    (done_ctr_o),
    .err_o         (err_o)
`ifdef TEST_CMD_RESP_WORD_COUNT_EN
    ,
    .word_cnt_o    (word_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [CTR_W-1:0] exp_ctr = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Select (optionally with validate) from IDLE/ARMED, then stream nbeats with random gaps and stray eofs
  task automatic do_scan(input int nbeats, input logic [CTR_W-1:0] ctr, input bit with_validate);
    int beats = 0;
    int early = 0;
    int errs = 0;
    int guard = 0;
    bit last;
    select_test_i = 1'b1;
    validate_i    = with_validate;
    ctr_i         = ctr;
    step();
    select_test_i = 1'b0;
    validate_i    = 1'b0;
    exp_ctr       = ctr;
    check("scan_rd_req", rd_req_o, 1);
    check("scan_busy", busy_o, 1);
    check("scan_accept_err", err_o, with_validate);
    check("scan_done_ctr", done_ctr_o, exp_ctr);
`ifdef TEST_CMD_RESP_WORD_COUNT_EN
    check("scan_word_cnt_clear", word_cnt_o, 0);
`endif
    while (beats < nbeats && guard < 1000) begin
      guard++;
      if ($urandom_range(0, 3) == 0) begin
        rd_valid_i = 1'b0;
        rd_eof_i   = 1'($urandom_range(0, 1));
      end else begin
        rd_valid_i = 1'b1;
        beats++;
        rd_eof_i   = (beats == nbeats);
      end
      rd_data_i = $urandom;
      ctr_i     = $urandom;
      last      = rd_valid_i && rd_eof_i;
      step();
      if (!last && sel_done_o) early++;
      if (err_o) errs++;
    end
    rd_valid_i = 1'b0;
    rd_eof_i   = 1'b0;
    check("scan_bounded", beats, nbeats);
    check("scan_no_early_done", early, 0);
    check("scan_no_err", errs, 0);
    check("scan_sel_done", sel_done_o, 1);
    check("scan_rd_req_drop", rd_req_o, 0);
    check("scan_busy_drop", busy_o, 0);
`ifdef TEST_CMD_RESP_WORD_COUNT_EN
    check("scan_word_cnt", word_cnt_o, nbeats);
`endif
    step();
    check("scan_sel_done_pulse", sel_done_o, 0);
    check("scan_done_ctr_hold", done_ctr_o, exp_ctr);
`ifdef TEST_CMD_RESP_WORD_COUNT_EN
    check("scan_word_cnt_hold", word_cnt_o, nbeats);
`endif
  endtask

  // Validate from ARMED; optional extra select at acceptance and a select pulse at cycle inject_t of the run
  task automatic run_val(input int inject_t, input bit both);
    int logs_seen = 0;
    int log_bad = 0;
    int done_t = -1;
    int done_cnt = 0;
    int err_ts[$];
    int exp_err[$];
    logic [CTR_W-1:0] ctr;
    ctr           = $urandom;
    validate_i    = 1'b1;
    select_test_i = both;
    ctr_i         = ctr;
    step();
    validate_i    = 1'b0;
    select_test_i = 1'b0;
    exp_ctr       = ctr;
    check("val_busy_start", busy_o, 1);
    check("val_done_ctr", done_ctr_o, exp_ctr);
    for (int t = 0; t < PERIOD + 8; t++) begin
      if (err_o) err_ts.push_back(t);
      if (log_valid_o) begin
        // k-th log carries count 1 + k*2^LOG_SHIFT; the count equals t+1 in cycle t and shows one cycle later
        if (log_data_o !== CNT_W'(1 + logs_seen * LOG_STEP) || t != 1 + logs_seen * LOG_STEP) log_bad++;
        logs_seen++;
      end
      if (val_done_o) begin
        done_cnt++;
        if (done_t < 0) begin
          done_t = t;
          check("val_busy_at_done", busy_o, 1);
        end
      end
      if (done_t >= 0 && t == done_t + 1) begin
        check("val_busy_after_done", busy_o, 0);
        break;
      end
      select_test_i = (t == inject_t);
      step();
    end
    select_test_i = 1'b0;
    check("val_log_count", logs_seen, LOGS);
    check("val_log_bad", log_bad, 0);
    check("val_done_time", done_t, PERIOD - 1);
    check("val_done_count", done_cnt, 1);
    if (both) exp_err.push_back(0);
    if (inject_t >= 0) exp_err.push_back(inject_t + 1);
    check("val_err_count", err_ts.size(), exp_err.size());
    for (int i = 0; i < exp_err.size() && i < err_ts.size(); i++)
      check("val_err_time", err_ts[i], exp_err[i]);
  endtask

  initial begin
    // reset state
    step();
    step();
    check("rst_rd_req", rd_req_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_sel_done", sel_done_o, 0);
    check("rst_val_done", val_done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_log_valid", log_valid_o, 0);
    check("rst_log_data", log_data_o, 0);
    check("rst_done_ctr", done_ctr_o, 0);
`ifdef TEST_CMD_RESP_WORD_COUNT_EN
    check("rst_word_cnt", word_cnt_o, 0);
`endif
    rst_n = 1'b1;
    step();

    // validate alone in IDLE is rejected
    validate_i = 1'b1;
    ctr_i      = $urandom;
    step();
    validate_i = 1'b0;
    check("idle_val_err", err_o, 1);
    check("idle_val_busy", busy_o, 0);
    check("idle_val_rd_req", rd_req_o, 0);
    step();
    check("idle_val_err_pulse", err_o, 0);
    check("idle_val_busy2", busy_o, 0);
    check("idle_val_done_ctr", done_ctr_o, 0);

    // scan with ctr 3, five beats; then a full validate run
    do_scan(5, 32'd3, 1'b0);
    run_val(-1, 1'b0);

    // both strobes in IDLE -> scan plus err; re-scan from ARMED; validate with a mid-run select
    do_scan($urandom_range(1, 20), $urandom, 1'b1);
    do_scan($urandom_range(1, 20), $urandom, 1'b0);
    run_val($urandom_range(100, 3000), 1'b0);

    // select held three cycles in IDLE: accepted once, the two held cycles in SCAN raise err
    select_test_i = 1'b1;
    ctr_i         = $urandom;
    exp_ctr       = ctr_i;
    step();
    check("held_err0", err_o, 0);
    check("held_rd_req", rd_req_o, 1);
    step();
    check("held_err1", err_o, 1);
    step();
    select_test_i = 1'b0;
    check("held_err2", err_o, 1);
    check("held_done_ctr", done_ctr_o, exp_ctr);
    rd_valid_i = 1'b1;
    rd_eof_i   = 1'b1;
    step();
    rd_valid_i = 1'b0;
    rd_eof_i   = 1'b0;
    check("held_err3", err_o, 0);
    check("held_sel_done", sel_done_o, 1);

    // reset mid-scan after two beats aborts with no done pulse
    select_test_i = 1'b1;
    ctr_i         = $urandom;
    step();
    select_test_i = 1'b0;
    rd_valid_i    = 1'b1;
    step();
    step();
    rd_eof_i = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_rd_req", rd_req_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_done_ctr", done_ctr_o, 0);
    check("mid_rst_sel_done", sel_done_o, 0);
`ifdef TEST_CMD_RESP_WORD_COUNT_EN
    check("mid_rst_word_cnt", word_cnt_o, 0);
`endif
    step();
    rst_n      = 1'b1;
    rd_valid_i = 1'b0;
    rd_eof_i   = 1'b0;
    step();
    check("post_rst_sel_done", sel_done_o, 0);
    check("post_rst_busy", busy_o, 0);
    do_scan($urandom_range(1, 30), $urandom, 1'b0);

    // validate with both strobes in ARMED -> VAL plus err
    run_val(-1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_cmd_responder.md
Name: test_cmd_responder

Overview:
- Synthesizable responder for the SelectTest/Validate strobe protocol that the bench drives on posedge clk.
- A select strobe scans a word stream until end-of-stream.
- A following validate strobe runs a free-running wrap-around counter and emits a log beat every 2**LOG_SHIFT counts.
- Sits between the test sequencer (initiator) and a stream source / log sink. It reports busy, done and protocol errors back to the sequencer.

Parameters:
- DATA_W, 32: read-stream word width
- CNT_W, 16: validate counter width; the loop ends on wrap to 0
- LOG_SHIFT, 10: log period exponent; must satisfy 1 <= LOG_SHIFT < CNT_W
- CTR_W, 32: width of the test index tag

Ports:
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- select_test_i  in  1  select strobe, sampled on posedge
- validate_i  in  1  validate strobe, sampled on posedge
- ctr_i  in  CTR_W  test index, latched with an accepted strobe
- rd_req_o  out  1  stream request, high throughout SCAN
- rd_valid_i  in  1  stream beat valid
- rd_data_i  in  DATA_W  stream data; consumed but not stored
- rd_eof_i  in  1  qualifies the last beat (valid only with rd_valid_i)
- log_valid_o  out  1  log beat strobe
- log_data_o  out  CNT_W  counter value being logged
- busy_o  out  1  high in SCAN or VAL
- sel_done_o  out  1  1-cycle pulse at scan completion
- val_done_o  out  1  1-cycle pulse at validate completion
- done_ctr_o  out  CTR_W  latched ctr_i of the current/last operation
- err_o  out  1  1-cycle pulse on a rejected strobe

Behaviour:
- Reset (async assert, sync deassert is upstream's job):
  - state=IDLE; all outputs 0; done_ctr_o=0; counter=0.
  - A reset mid-SCAN/VAL aborts with no done pulse.
- States: IDLE, SCAN, ARMED, VAL.
- IDLE:
  - select_test_i=1: latch ctr_i into done_ctr_o; go to SCAN next cycle.
  - validate_i=1 alone: err_o pulses next cycle; stay in IDLE.
  - Both strobes together: select wins, err_o pulses.
- SCAN:
  - rd_req_o=1, busy_o=1.
  - Each rd_valid_i beat is consumed.
  - Beat with rd_eof_i=1: sel_done_o pulses next cycle, state goes to ARMED, rd_req_o drops in that same next cycle.
  - rd_eof_i without rd_valid_i is ignored.
- ARMED:
  - validate_i=1: latch ctr_i; go to VAL; counter=1 in the first VAL cycle.
  - select_test_i=1 (without validate_i): re-scan, same as IDLE.
  - Both strobes together: validate wins, err_o pulses.
- VAL:
  - busy_o=1; counter increments by 1 every cycle, modulo 2**CNT_W.
  - Log rule: when counter[LOG_SHIFT-1:0]==1, log_valid_o=1 and log_data_o=counter on the following cycle (registered, 1-cycle latency).
  - Completion: when the counter increments from 2**CNT_W-1 to 0, val_done_o pulses in the cycle holding 0 and the state goes to IDLE.
  - Duration: first VAL cycle N0, val_done_o at N0+2**CNT_W-1.
  - Logs per run: 2**(CNT_W-LOG_SHIFT).
- Any strobe while busy_o=1 is dropped and err_o pulses next cycle. State and counter are unaffected.
- Strobes are level-sampled. A strobe held high for k cycles in IDLE/ARMED is accepted once. The held cycles after acceptance fall in the busy state and each raises err_o.
- done pulses and err_o in the same cycle are legal and independent.

Optional Feature:
- Macro TEST_CMD_RESP_WORD_COUNT_EN.
- Defined:
  - Extra output word_cnt_o [15:0]: counts the rd_valid_i beats of the current scan, including the eof beat. Saturates at 16'hFFFF.
  - Cleared on scan start; held stable after sel_done_o until the next scan.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package test_cmd_resp_pkg: state enum (IDLE, SCAN, ARMED, VAL), word-count width localparam, and a log-mask function of LOG_SHIFT.
- Sub-module resp_wrap_counter (CNT_W): load-to-1, increment, wrap flag, log-hit flag. Reused by the VAL state.

Test Plan:
- Reset, then select (ctr_i=3), then 5 beats with eof on the 5th -> sel_done_o pulse 1 cycle after the 5th beat, done_ctr_o=3, rd_req_o low afterwards; word_cnt_o=5 when the macro is defined.
- CNT_W=12, LOG_SHIFT=10, validate in ARMED -> log_data_o sequence 1, 1025, 2049, 3073; val_done_o exactly 4095 cycles after the first VAL cycle; busy_o low next cycle.
- validate_i in IDLE with no prior select -> err_o pulse, no VAL entry, busy_o stays 0.
- select_test_i pulsed mid-VAL -> err_o pulse, counter sequence and val_done_o timing unchanged.
- select+validate together in IDLE -> SCAN entered, err_o pulses; the same pair in ARMED -> VAL entered, err_o pulses.
- rst_n low for 1 cycle mid-SCAN (after 2 beats) -> outputs 0 immediately, no sel_done_o; a new select then scans normally from a zero count.
